// File: rtl/ucsbece154b_issue_scheduler.sv
// Dual-issue instruction buffer and pair scheduler.
// Fetch pushes up to two instructions per cycle into a circular queue.
// Each cycle the oldest entry goes to slot 1. The next entry goes to slot 2
// only when the pair has no RAW/WAW hazard, no control-flow instruction,
// at most one memory operation, and only known opcodes.
module ucsbece154b_issue_scheduler #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              f0_valid_i,
    input  logic [31:0]       f0_instr_i,
    input  logic [31:0]       f0_pc_i,
    input  logic              f1_valid_i,
    input  logic [31:0]       f1_instr_i,
    input  logic [31:0]       f1_pc_i,
    output logic              fetch_ready_o,
    output logic              i0_valid_o,
    output logic [31:0]       i0_instr_o,
    output logic [31:0]       i0_pc_o,
    output logic              i1_valid_o,
    output logic [31:0]       i1_instr_o,
    output logic [31:0]       i1_pc_o,
    output logic [PTRW:0]     count_o,
    output logic [31:0]       dual_cnt_o,
    output logic [31:0]       single_cnt_o
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [PTRW:0] READY_LIMIT = (PTRW+1)'(DEPTH - 2);
    localparam logic [PTRW:0] TWO         = (PTRW+1)'(2);

    function automatic logic known_op(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_IALU, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_LW, OP_R, OP_IALU, OP_JAL, OP_LUI, OP_JALR};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_BR, OP_SW, OP_LW, OP_IALU, OP_JALR};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_BR, OP_SW};
    endfunction

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];
    logic [PTRW-1:0] head, tail, head_p1, tail_p1;
    logic [PTRW:0]   count;
    logic [31:0]     dual_cnt, single_cnt;
    logic            push0, push1, pair_ok;
    logic [1:0]      pushed, popped;
    logic [6:0]      op0, op1;
    logic [4:0]      rd0, rd1, rs1_1, rs2_1;

    assign head_p1 = head + 1'b1;
    assign tail_p1 = tail + 1'b1;

    // Ready depends on registered occupancy only, so fetch never sees a path from stall/issue.
    assign fetch_ready_o = (count <= READY_LIMIT);
    assign push0  = fetch_ready_o & f0_valid_i;
    assign push1  = push0 & f1_valid_i;
    assign pushed = {1'b0, push0} + {1'b0, push1};

    assign i0_instr_o = instr_mem[head];
    assign i0_pc_o    = pc_mem[head];
    assign i1_instr_o = instr_mem[head_p1];
    assign i1_pc_o    = pc_mem[head_p1];

    assign op0   = i0_instr_o[6:0];
    assign rd0   = i0_instr_o[11:7];
    assign op1   = i1_instr_o[6:0];
    assign rd1   = i1_instr_o[11:7];
    assign rs1_1 = i1_instr_o[19:15];
    assign rs2_1 = i1_instr_o[24:20];

    // Pairing rules; a WAR between the two slots is harmless because both read in order.
    always_comb begin
        logic raw, waw, ctrl, mem2, bad;
        raw  = writes_rd(op0) && (rd0 != 5'd0) &&
               ((uses_rs1(op1) && (rs1_1 == rd0)) || (uses_rs2(op1) && (rs2_1 == rd0)));
        waw  = writes_rd(op0) && writes_rd(op1) && (rd0 == rd1) && (rd0 != 5'd0);
        ctrl = (op0 inside {OP_BR, OP_JAL, OP_JALR}) || (op1 inside {OP_BR, OP_JAL, OP_JALR});
        mem2 = (op0 inside {OP_LW, OP_SW}) && (op1 inside {OP_LW, OP_SW});
        bad  = !known_op(op0) || !known_op(op1);
        pair_ok = !(raw || waw || ctrl || mem2 || bad);
    end

    assign i0_valid_o = (count != '0) && !flush_i;
    assign i1_valid_o = (count >= TWO) && pair_ok && !flush_i;
    assign popped     = stall_i ? 2'd0 : ({1'b0, i0_valid_o} + {1'b0, i1_valid_o});

    // Entry storage is data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!flush_i && push0) begin
            instr_mem[tail] <= f0_instr_i;
            pc_mem[tail]    <= f0_pc_i;
        end
        if (!flush_i && push1) begin
            instr_mem[tail_p1] <= f1_instr_i;
            pc_mem[tail_p1]    <= f1_pc_i;
        end
    end

    // Pointer and occupancy update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTRW'(popped);
            tail  <= tail + PTRW'(pushed);
            count <= count + (PTRW+1)'(pushed) - (PTRW+1)'(popped);
        end
    end

    // Saturating issue-width counters; flush does not clear them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dual_cnt   <= '0;
            single_cnt <= '0;
        end else begin
            if (popped == 2'd2 && dual_cnt != 32'hFFFF_FFFF)
                dual_cnt <= dual_cnt + 32'd1;
            if (popped == 2'd1 && single_cnt != 32'hFFFF_FFFF)
                single_cnt <= single_cnt + 32'd1;
        end
    end

    assign count_o      = count;
    assign dual_cnt_o   = dual_cnt;
    assign single_cnt_o = single_cnt;

endmodule

// File: tb/tb_ucsbece154b_issue_scheduler.sv
// Directed bench for the dual-issue scheduler with hand-computed expectations.
module tb_ucsbece154b_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset, flush, stall;
    logic        f0_valid, f1_valid;
    logic [31:0] f0_instr, f0_pc, f1_instr, f1_pc;
    logic        fetch_ready, i0_valid, i1_valid;
    logic [31:0] i0_instr, i0_pc, i1_instr, i1_pc;
    logic [2:0]  count;
    logic [31:0] dual_cnt, single_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] ADDI_X2 = 32'h0070_0113;
    localparam logic [31:0] ADD_X2  = 32'h0010_8133;
    localparam logic [31:0] LW_X3   = 32'h0000_2183;
    localparam logic [31:0] SW_X4   = 32'h0040_2223;
    localparam logic [31:0] ADDI_X5 = 32'h0010_0293;
    localparam logic [31:0] ADDI_X6 = 32'h0020_0313;
    localparam logic [31:0] ADDI_X7 = 32'h0030_0393;
    localparam logic [31:0] ADDI_X8 = 32'h0040_0413;
    localparam logic [31:0] BEQ     = 32'h0000_0063;

    ucsbece154b_issue_scheduler #(.DEPTH(4), .PTRW(2)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .stall_i(stall),
        .f0_valid_i(f0_valid), .f0_instr_i(f0_instr), .f0_pc_i(f0_pc),
        .f1_valid_i(f1_valid), .f1_instr_i(f1_instr), .f1_pc_i(f1_pc),
        .fetch_ready_o(fetch_ready),
        .i0_valid_o(i0_valid), .i0_instr_o(i0_instr), .i0_pc_o(i0_pc),
        .i1_valid_o(i1_valid), .i1_instr_o(i1_instr), .i1_pc_o(i1_pc),
        .count_o(count), .dual_cnt_o(dual_cnt), .single_cnt_o(single_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic v0, input logic [31:0] ins0, input logic [31:0] p0,
                         input logic v1, input logic [31:0] ins1, input logic [31:0] p1);
        f0_valid = v0; f0_instr = ins0; f0_pc = p0;
        f1_valid = v1; f1_instr = ins1; f1_pc = p1;
    endtask

    task automatic idle();
        fetch(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        idle();
        tick(); tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(fetch_ready), 1);
        chk("rst_i0v", 32'(i0_valid), 0);
        chk("rst_i1v", 32'(i1_valid), 0);
        chk("rst_dual", dual_cnt, 0);
        chk("rst_single", single_cnt, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 0);

        // independent addi pair -> dual issue
        fetch(1'b1, ADDI_X1, 32'h100, 1'b1, ADDI_X2, 32'h104);
        tick(); idle();
        chk("t1_i0v", 32'(i0_valid), 1);
        chk("t1_i1v", 32'(i1_valid), 1);
        chk("t1_i0pc", i0_pc, 32'h100);
        chk("t1_i1instr", i1_instr, ADDI_X2);
        chk("t1_count", 32'(count), 2);
        tick();
        chk("t1_count_after", 32'(count), 0);
        chk("t1_dual", dual_cnt, 1);
        chk("t1_i0v_empty", 32'(i0_valid), 0);

        // RAW hazard -> singles
        fetch(1'b1, ADDI_X1, 32'h200, 1'b1, ADD_X2, 32'h204);
        tick(); idle();
        chk("t2_i0v", 32'(i0_valid), 1);
        chk("t2_i1v", 32'(i1_valid), 0);
        chk("t2_i0pc", i0_pc, 32'h200);
        tick();
        chk("t2_i0instr", i0_instr, ADD_X2);
        chk("t2_i1v2", 32'(i1_valid), 0);
        chk("t2_count", 32'(count), 1);
        tick();
        chk("t2_single", single_cnt, 2);
        chk("t2_dual", dual_cnt, 1);

        // lw + sw share one data port -> singles
        fetch(1'b1, LW_X3, 32'h300, 1'b1, SW_X4, 32'h304);
        tick(); idle();
        chk("t3_i0instr", i0_instr, LW_X3);
        chk("t3_i1v", 32'(i1_valid), 0);
        tick();
        chk("t3_i0pc", i0_pc, 32'h304);
        chk("t3_i1v2", 32'(i1_valid), 0);
        tick();
        chk("t3_single", single_cnt, 4);
        chk("t3_count", 32'(count), 0);

        // fill under stall, wrap pointers, drain in push order
        stall = 1'b1;
        fetch(1'b1, ADDI_X1, 32'h400, 1'b1, ADDI_X2, 32'h404);
        tick();
        chk("t4_ready_half", 32'(fetch_ready), 1);
        fetch(1'b1, ADDI_X5, 32'h408, 1'b1, ADDI_X6, 32'h40C);
        tick();
        chk("t4_full_count", 32'(count), 4);
        chk("t4_full_ready", 32'(fetch_ready), 0);
        chk("t4_hold_i0pc", i0_pc, 32'h400);
        chk("t4_hold_i1pc", i1_pc, 32'h404);
        fetch(1'b1, ADDI_X7, 32'h410, 1'b1, ADDI_X8, 32'h414);
        tick();
        chk("t4_stall_count", 32'(count), 4);
        chk("t4_stall_i0pc", i0_pc, 32'h400);
        stall = 1'b0;
        tick();
        chk("t4_drain1_count", 32'(count), 2);
        chk("t4_drain1_i0pc", i0_pc, 32'h408);
        chk("t4_drain1_i1pc", i1_pc, 32'h40C);
        tick(); idle();
        chk("t4_drain2_count", 32'(count), 2);
        chk("t4_drain2_i0pc", i0_pc, 32'h410);
        chk("t4_drain2_i1pc", i1_pc, 32'h414);
        tick();
        chk("t4_empty", 32'(count), 0);
        chk("t4_dual", dual_cnt, 4);

        // build count=3, check f1-only is ignored, then flush
        stall = 1'b1;
        fetch(1'b1, ADDI_X1, 32'h500, 1'b1, ADDI_X2, 32'h504);
        tick();
        fetch(1'b1, ADDI_X5, 32'h508, 1'b0, 32'h0, 32'h0);
        tick();
        fetch(1'b0, 32'h0, 32'h0, 1'b1, ADDI_X6, 32'h50C);
        tick();
        chk("t5_count3", 32'(count), 3);
        stall = 1'b0; flush = 1'b1;
        fetch(1'b1, ADDI_X7, 32'h510, 1'b1, ADDI_X8, 32'h514);
        #1;
        chk("t5_flush_i0v", 32'(i0_valid), 0);
        chk("t5_flush_i1v", 32'(i1_valid), 0);
        tick(); flush = 1'b0; idle(); #1;
        chk("t5_count0", 32'(count), 0);
        chk("t5_i0v", 32'(i0_valid), 0);
        chk("t5_dual", dual_cnt, 4);
        chk("t5_single", single_cnt, 4);

        // branch never pairs; head restarted at 0 after flush
        fetch(1'b1, ADDI_X1, 32'h600, 1'b1, BEQ, 32'h604);
        tick(); idle();
        chk("t6_i0pc", i0_pc, 32'h600);
        chk("t6_i1v", 32'(i1_valid), 0);
        tick();
        chk("t6_i0instr", i0_instr, BEQ);
        tick();
        chk("t6_single", single_cnt, 6);

        // WAR across the pair is allowed
        fetch(1'b1, ADD_X2, 32'h700, 1'b1, ADDI_X1, 32'h704);
        tick(); idle();
        chk("t7_i1v", 32'(i1_valid), 1);
        tick();
        chk("t7_dual", dual_cnt, 5);

        // async reset mid-operation
        fetch(1'b1, ADDI_X1, 32'h800, 1'b1, ADDI_X2, 32'h804);
        stall = 1'b1;
        tick(); idle();
        chk("t8_count_pre", 32'(count), 2);
        #2 reset = 1'b0; #1;
        chk("t8_rst_count", 32'(count), 0);
        chk("t8_rst_i0v", 32'(i0_valid), 0);
        chk("t8_rst_dual", dual_cnt, 0);
        chk("t8_rst_single", single_cnt, 0);
        reset = 1'b1;
        tick();
        chk("t8_released_count", 32'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
